// File: rtl/serv_arb_wdog.sv
// Per-transaction watchdog for serv_mem_arbiter.
// Counts grant cycles that pass without an acknowledge and flags the cycle
// in which the count reaches TIMEOUT-1.
//   clk      : system clock
//   i_rst_n  : asynchronous active-low reset
//   i_clr    : hold the count at zero (arbiter idle)
//   i_en     : a granted cycle with cyc high and no ack
//   o_expire : combinational, high in the cycle the watchdog fires
module serv_arb_wdog #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = $clog2(TIMEOUT+1)
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  logic [CNT_W-1:0] cnt;

  // Every grant is preceded by at least one idle cycle, so clearing while idle
  // guarantees a zero count on entry to a grant state.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)   cnt <= '0;
    else if (i_clr) cnt <= '0;
    else if (i_en)  cnt <= cnt + CNT_W'(1);
  end

  assign o_expire = i_en && (cnt == CNT_W'(TIMEOUT-1));

endmodule

// File: rtl/serv_mem_arbiter.sv
// Round-robin arbiter sharing one Wishbone memory port between SERV's ibus
// and dbus, with a per-transaction watchdog that terminates unacknowledged
// transfers with an error response (ack + rdt all-ones).
//   clk, i_rst_n        : clock, asynchronous active-low reset
//   i_ibus_* / o_ibus_* : instruction fetch port (read only)
//   i_dbus_* / o_dbus_* : data port (read/write)
//   o_mem_* / i_mem_*   : shared memory port
//   o_timeout           : one-cycle pulse when the watchdog fires
//   o_err_src           : source of the last timeout (0 ibus, 1 dbus)
module serv_mem_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = $clog2(TIMEOUT+1)
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  output logic [31:0] o_mem_adr,
  output logic [31:0] o_mem_dat,
  output logic [3:0]  o_mem_sel,
  output logic        o_mem_we,
  output logic        o_mem_cyc,
  input  logic [31:0] i_mem_rdt,
  input  logic        i_mem_ack,
  output logic        o_timeout,
  output logic        o_err_src
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;

  logic [1:0] state, state_n;
  logic       last_d, last_d_n;
  logic       err_src;
  logic       gnt_i, gnt_d, x_cyc, expire, done;

  assign gnt_i = (state == GNT_I);
  assign gnt_d = (state == GNT_D);
  // Granted requester still holding its cycle; low in an abort cycle.
  assign x_cyc = (gnt_i & i_ibus_cyc) | (gnt_d & i_dbus_cyc);

  serv_arb_wdog #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_wdog (
    .clk      (clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (state == IDLE),
    .i_en     (x_cyc & ~i_mem_ack),
    .o_expire (expire)
  );

  // Completion: slave ack, or watchdog termination (ack has priority inside
  // the watchdog enable, so both never count at once).
  assign done = x_cyc & (i_mem_ack | expire);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      last_d  <= 1'b0;
      err_src <= 1'b0;
    end else begin
      state  <= state_n;
      last_d <= last_d_n;
      if (expire) err_src <= gnt_d;
    end
  end

  always_comb begin
    state_n  = state;
    last_d_n = last_d;
    case (state)
      IDLE: begin
        if (i_ibus_cyc && i_dbus_cyc) state_n = last_d ? GNT_I : GNT_D;
        else if (i_ibus_cyc)          state_n = GNT_I;
        else if (i_dbus_cyc)          state_n = GNT_D;
      end
      GNT_I, GNT_D: begin
        if (!x_cyc) begin
          state_n = IDLE;              // abort: fairness history untouched
        end else if (done) begin
          state_n  = IDLE;
          last_d_n = gnt_d;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    o_mem_adr  = '0;
    o_mem_dat  = '0;
    o_mem_sel  = '0;
    o_mem_we   = 1'b0;
    o_ibus_ack = 1'b0;
    o_ibus_rdt = '0;
    o_dbus_ack = 1'b0;
    o_dbus_rdt = '0;
    o_mem_cyc  = x_cyc & ~expire;
    o_timeout  = expire;
    if (gnt_i) begin
      o_mem_adr  = i_ibus_adr;
      o_mem_sel  = 4'hF;
      o_ibus_ack = done;
      o_ibus_rdt = expire ? 32'hFFFF_FFFF : i_mem_rdt;
    end
    if (gnt_d) begin
      o_mem_adr  = i_dbus_adr;
      o_mem_dat  = i_dbus_dat;
      o_mem_sel  = i_dbus_sel;
      o_mem_we   = i_dbus_we;
      o_dbus_ack = done;
      o_dbus_rdt = expire ? 32'hFFFF_FFFF : i_mem_rdt;
    end
  end

  assign o_err_src = err_src;

endmodule

// File: tb/tb_serv_mem_arbiter.sv
module tb_serv_mem_arbiter;
  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ibus_adr, dbus_adr, dbus_dat, mem_rdt;
  logic [3:0]  dbus_sel;
  logic        ibus_cyc, dbus_we, dbus_cyc, mem_ack;
  logic [31:0] ibus_rdt, dbus_rdt, mem_adr, mem_dat;
  logic [3:0]  mem_sel;
  logic        ibus_ack, dbus_ack, mem_we, mem_cyc, timeout, err_src;

  always #5 clk = ~clk;

  serv_mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .i_rst_n(rst_n),
    .i_ibus_adr(ibus_adr), .i_ibus_cyc(ibus_cyc), .o_ibus_rdt(ibus_rdt), .o_ibus_ack(ibus_ack),
    .i_dbus_adr(dbus_adr), .i_dbus_dat(dbus_dat), .i_dbus_sel(dbus_sel), .i_dbus_we(dbus_we),
    .i_dbus_cyc(dbus_cyc), .o_dbus_rdt(dbus_rdt), .o_dbus_ack(dbus_ack),
    .o_mem_adr(mem_adr), .o_mem_dat(mem_dat), .o_mem_sel(mem_sel), .o_mem_we(mem_we),
    .o_mem_cyc(mem_cyc), .i_mem_rdt(mem_rdt), .i_mem_ack(mem_ack),
    .o_timeout(timeout), .o_err_src(err_src)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: who owns the port (0 none, 1 ibus, 2 dbus), how many grant
  // cycles have passed without completion, who was served last, last error.
  int owner, age;
  bit m_last_d, m_err;

  logic [31:0] e_adr, e_dat, e_irdt, e_drdt;
  logic [3:0]  e_sel;
  logic        e_we, e_cyc, e_iack, e_dack, e_tmo;

  // Snapshots of DUT outputs from the most recent checked cycle.
  logic [31:0] s_adr, s_dat, s_irdt, s_drdt;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc, s_iack, s_dack, s_tmo, s_err;

  function automatic bit owner_cyc();
    return (owner == 1) ? ibus_cyc : (owner == 2) ? dbus_cyc : 1'b0;
  endfunction

  task automatic model_reset();
    owner = 0; age = 0; m_last_d = 0; m_err = 0;
  endtask

  task automatic predict();
    bit rq, fire;
    e_adr = 0; e_dat = 0; e_sel = 0; e_we = 0; e_cyc = 0;
    e_iack = 0; e_dack = 0; e_irdt = 0; e_drdt = 0; e_tmo = 0;
    if (owner != 0) begin
      rq   = owner_cyc();
      fire = rq && !mem_ack && (age == TIMEOUT-1);
      e_cyc = rq && !fire;
      e_tmo = fire;
      if (owner == 1) begin
        e_adr = ibus_adr; e_sel = 4'hF;
        e_iack = rq && (mem_ack || fire);
        e_irdt = fire ? 32'hFFFF_FFFF : mem_rdt;
      end else begin
        e_adr = dbus_adr; e_dat = dbus_dat; e_sel = dbus_sel; e_we = dbus_we;
        e_dack = rq && (mem_ack || fire);
        e_drdt = fire ? 32'hFFFF_FFFF : mem_rdt;
      end
    end
  endtask

  // Check one cycle at the falling edge, advance the model, return just
  // after the next rising edge so the caller can drive new inputs.
  task automatic cycle();
    @(negedge clk);
    predict();
    s_adr = mem_adr; s_dat = mem_dat; s_sel = mem_sel; s_we = mem_we; s_cyc = mem_cyc;
    s_iack = ibus_ack; s_irdt = ibus_rdt; s_dack = dbus_ack; s_drdt = dbus_rdt;
    s_tmo = timeout; s_err = err_src;
    chk("mem_adr", mem_adr, e_adr);
    chk("mem_dat", mem_dat, e_dat);
    chk("mem_sel", 32'(mem_sel), 32'(e_sel));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_cyc", 32'(mem_cyc), 32'(e_cyc));
    chk("ibus_ack", 32'(ibus_ack), 32'(e_iack));
    chk("ibus_rdt", ibus_rdt, e_irdt);
    chk("dbus_ack", 32'(dbus_ack), 32'(e_dack));
    chk("dbus_rdt", dbus_rdt, e_drdt);
    chk("timeout", 32'(timeout), 32'(e_tmo));
    chk("err_src", 32'(err_src), 32'(m_err));
    if (owner == 0) begin
      if (ibus_cyc && dbus_cyc) owner = m_last_d ? 1 : 2;
      else if (ibus_cyc)        owner = 1;
      else if (dbus_cyc)        owner = 2;
      age = 0;
    end else if (!owner_cyc()) begin
      owner = 0;
    end else if (e_iack || e_dack) begin
      if (e_tmo) m_err = (owner == 2);
      m_last_d = (owner == 2);
      owner = 0;
    end else begin
      age++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    ibus_adr = 0; ibus_cyc = 0; dbus_adr = 0; dbus_dat = 0; dbus_sel = 0;
    dbus_we = 0; dbus_cyc = 0; mem_rdt = 0; mem_ack = 0;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();

    // Single fetch: ack one cycle after the grant starts.
    ibus_cyc = 1; ibus_adr = 32'h100;
    cycle();
    cycle();
    mem_ack = 1; mem_rdt = 32'h13;
    cycle();
    chk("fetch_adr", s_adr, 32'h100);
    chk("fetch_ack", 32'(s_iack), 1);
    chk("fetch_rdt", s_irdt, 32'h13);
    chk("fetch_dack", 32'(s_dack), 0);
    ibus_cyc = 0; mem_ack = 0;
    cycle();

    // Contention: dbus first, then held ibus, then dbus again.
    ibus_cyc = 1; ibus_adr = 32'h200; dbus_cyc = 1; dbus_adr = 32'h300;
    cycle();
    mem_ack = 1;
    cycle();
    chk("cont1_dack", 32'(s_dack), 1);
    chk("cont1_iack", 32'(s_iack), 0);
    dbus_cyc = 0; mem_ack = 0;
    cycle();
    mem_ack = 1;
    cycle();
    chk("cont2_iack", 32'(s_iack), 1);
    ibus_cyc = 0; mem_ack = 0;
    cycle();
    ibus_cyc = 1; dbus_cyc = 1;
    cycle();
    mem_ack = 1;
    cycle();
    chk("cont3_dack", 32'(s_dack), 1);
    ibus_cyc = 0; dbus_cyc = 0; mem_ack = 0;
    cycle();

    // Store passthrough, then ibus forcing we=0, sel=F.
    dbus_cyc = 1; dbus_adr = 32'h2000; dbus_dat = 32'hDEADBEEF; dbus_sel = 4'b0011; dbus_we = 1;
    cycle();
    cycle();
    chk("st_adr", s_adr, 32'h2000);
    chk("st_dat", s_dat, 32'hDEADBEEF);
    chk("st_sel", 32'(s_sel), 32'h3);
    chk("st_we", 32'(s_we), 1);
    mem_ack = 1;
    cycle();
    dbus_cyc = 0; mem_ack = 0; ibus_cyc = 1;
    cycle();
    cycle();
    chk("gi_we", 32'(s_we), 0);
    chk("gi_sel", 32'(s_sel), 32'hF);
    mem_ack = 1;
    cycle();
    ibus_cyc = 0; mem_ack = 0; dbus_we = 0;
    cycle();

    // Timeout on dbus in the 4th grant cycle.
    dbus_cyc = 1; mem_rdt = 32'h1234;
    cycle();
    repeat (3) cycle();
    cycle();
    chk("to_dack", 32'(s_dack), 1);
    chk("to_tmo", 32'(s_tmo), 1);
    chk("to_rdt", s_drdt, 32'hFFFFFFFF);
    chk("to_cyc", 32'(s_cyc), 0);
    dbus_cyc = 0;
    cycle();
    chk("to_err", 32'(s_err), 1);

    // Ack in the 4th grant cycle wins over the watchdog.
    dbus_cyc = 1;
    cycle();
    repeat (3) cycle();
    mem_ack = 1; mem_rdt = 32'h5;
    cycle();
    chk("late_tmo", 32'(s_tmo), 0);
    chk("late_rdt", s_drdt, 32'h5);
    dbus_cyc = 0; mem_ack = 0;
    cycle();

    // Abort: ibus wins (last was dbus), drops cyc in its 2nd grant cycle.
    ibus_cyc = 1; dbus_cyc = 1;
    cycle();
    cycle();
    ibus_cyc = 0;
    cycle();
    chk("ab_cyc", 32'(s_cyc), 0);
    chk("ab_iack", 32'(s_iack), 0);
    cycle();
    mem_ack = 1;
    cycle();
    chk("ab_dack", 32'(s_dack), 1);
    dbus_cyc = 0; mem_ack = 0;
    cycle();

    // Reset mid-grant on dbus: outputs drop without a clock edge.
    dbus_cyc = 1; dbus_adr = 32'h44; dbus_we = 1; dbus_sel = 4'h1;
    cycle();
    #2 mem_ack = 1;
    rst_n = 1'b0;
    #1;
    chk("rst_cyc", 32'(mem_cyc), 0);
    chk("rst_adr", mem_adr, 0);
    chk("rst_dack", 32'(dbus_ack), 0);
    chk("rst_we", 32'(mem_we), 0);
    model_reset();
    dbus_cyc = 0; dbus_we = 0;
    cycle();
    rst_n = 1'b1; mem_ack = 0;
    ibus_cyc = 1; dbus_cyc = 1;
    cycle();
    mem_ack = 1;
    cycle();
    chk("rst_first_d", 32'(s_dack), 1);
    ibus_cyc = 0; dbus_cyc = 0; mem_ack = 0;
    cycle();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if (ibus_cyc) begin
        if (e_iack) begin
          if ($urandom_range(1, 0) == 1) ibus_adr = $urandom & ~32'h3;
          else ibus_cyc = 0;
        end else if ($urandom_range(19, 0) == 0) ibus_cyc = 0;
      end else if ($urandom_range(2, 0) == 0) begin
        ibus_cyc = 1; ibus_adr = $urandom & ~32'h3;
      end
      if (dbus_cyc) begin
        if (e_dack) dbus_cyc = 0;
        else if ($urandom_range(19, 0) == 0) dbus_cyc = 0;
      end else if ($urandom_range(2, 0) == 0) begin
        dbus_cyc = 1; dbus_adr = $urandom; dbus_dat = $urandom;
        dbus_sel = 4'($urandom); dbus_we = 1'($urandom);
      end
      mem_rdt = $urandom;
      if (owner == 0)        mem_ack = ($urandom_range(3, 0) == 0);
      else if (owner_cyc())  mem_ack = ($urandom_range(3, 0) == 0);
      else                   mem_ack = 0;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
